// File: rtl/multi_port_op_queue.sv
// rtl/multi_port_op_queue.sv - dual-port op FIFO between decode and issue, 0..2 in and 0..2 out per cycle
module multi_port_op_queue #(
  parameter int DATA_W   = 88,
  parameter int DEPTH    = 16,
  parameter int AF_SLACK = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic [1:0]                   push_cnt_in,
  input  logic [DATA_W-1:0]            push_data0_in,
  input  logic [DATA_W-1:0]            push_data1_in,
  output logic                         push_ack_out,
  output logic [DATA_W-1:0]            head0_out,
  output logic [DATA_W-1:0]            head1_out,
  output logic [1:0]                   head_valid_out,
  input  logic [1:0]                   pop_cnt_in,
  output logic [$clog2(DEPTH):0]       count_out,
  output logic                         full_out,
  output logic                         almost_full_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] SLACK_C = CW'(AF_SLACK);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_front;
  logic [PW-1:0]     r_rear;
  logic [CW-1:0]     r_count;

  logic              w_active;
  logic [CW-1:0]     w_push_n;
  logic [CW-1:0]     w_pop_n;
  logic [CW-1:0]     w_free;
  logic              w_ack;
  logic [CW-1:0]     w_push_acc;
  logic [CW-1:0]     w_eff_pop;
  logic [PW-1:0]     w_front1;
  logic [PW-1:0]     w_rear1;

  // Request decode: a count of 3 is folded to 2, pops are clipped to what is held,
  // and space is judged on the registered count only (no same-cycle pop credit).
  always_comb begin
    w_active   = rdy_in & ~flush_in;
    w_push_n   = (push_cnt_in == 2'd3) ? CW'(2) : CW'(push_cnt_in);
    w_pop_n    = (pop_cnt_in  == 2'd3) ? CW'(2) : CW'(pop_cnt_in);
    w_free     = DEPTH_C - r_count;
    w_ack      = w_active & (w_push_n != '0) & (w_free >= w_push_n);
    w_push_acc = w_ack ? w_push_n : '0;
    w_eff_pop  = '0;
    if (w_active) begin
      w_eff_pop = (w_pop_n > r_count) ? r_count : w_pop_n;
    end
    w_front1   = r_front + PW'(1);
    w_rear1    = r_rear + PW'(1);
  end

  // Pointer and occupancy state; flush behaves exactly like reset and wins over push/pop.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || flush_in) begin
      r_front <= '0;
      r_rear  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      r_rear  <= r_rear + w_push_acc[PW-1:0];
      r_front <= r_front + w_eff_pop[PW-1:0];
      r_count <= r_count + w_push_acc - w_eff_pop;
    end
  end

  // Entry storage is never cleared; validity comes only from the occupancy count.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && w_ack) begin
      r_mem[r_rear] <= push_data0_in;
      if (w_push_n == CW'(2)) begin
        r_mem[w_rear1] <= push_data1_in;
      end
    end
  end

  // Status and head outputs, each head gated to zero when not backed by a live entry.
  always_comb begin
    push_ack_out      = w_ack;
    count_out         = r_count;
    full_out          = (r_count == DEPTH_C);
    almost_full_out   = ((DEPTH_C - r_count) <= SLACK_C);
    head_valid_out[0] = (r_count >= CW'(1));
    head_valid_out[1] = (r_count >= CW'(2));
    head0_out         = head_valid_out[0] ? r_mem[r_front]  : '0;
    head1_out         = head_valid_out[1] ? r_mem[w_front1] : '0;
  end

endmodule
